switch_key_input: RTL and testbench
===================================

# switch_key_input

Board-input front end for the CPU's memory-mapped IO space. Synchronizes and debounces the 16 slide switches and one confirm push-button, snapshots the debounced switch vector on each confirmed press, and serves the snapshot and a sticky key-valid flag to CPU IO reads. Its `display_data` output is the 16-bit value the seven-segment display driver shows as its switch-mode input, and it is the only source of that value.

## Interface
Parameters:
- `SW_WIDTH`, 16, number of switch inputs.
- `DEBOUNCE_CYCLES`, 1_000_000, stable cycles required before a switch or key change is accepted (10 ms at 100 MHz); legal range 2..2^20.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: synchronous, active-low reset.
- `sw_in` in SW_WIDTH: raw switch pins, asynchronous.
- `key_in` in 1: raw confirm button, active-high, asynchronous.
- `IORead` in 1: CPU IO read strobe, one cycle per access.
- `io_sel` in 1: 0 selects the switch snapshot, 1 selects key status.
- `io_read_data` out 16: data returned to the CPU.
- `display_data` out 16: current snapshot, to the display driver.
- `sw_stable` out SW_WIDTH: live debounced switch vector.
- `key_pulse` out 1: one-cycle strobe on each confirmed press.
- `key_valid` out 1: sticky flag set when a snapshot is taken and not yet read.

## Operation
- **Synchronization:** two flops on `sw_in` and on `key_in`, producing `sw_sync` and `key_sync`.
- **Switch debounce:** one shared counter, `sw_cnt`.
  - Clears whenever `sw_sync` differs from its previous-cycle value.
  - Otherwise increments, saturating at DEBOUNCE_CYCLES.
  - On the cycle `sw_cnt == DEBOUNCE_CYCLES-1`, `sw_stable <= sw_sync`.
  - Any toggle inside the window restarts it. A glitch that returns to the old value restarts the window but leaves `sw_stable` unchanged.
- **Key FSM:** states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, driven by its own counter `key_cnt`. The counter clears on every state change.
  - IDLE: `key_sync=1` goes to PRESS_WAIT.
  - PRESS_WAIT: `key_sync=0` returns to IDLE. When `key_cnt` reaches DEBOUNCE_CYCLES-1, go to PRESSED. That same edge registers `key_pulse=1`, `display_data<=sw_stable[15:0]` and `key_valid<=1`.
  - PRESSED: `key_sync=0` goes to RELEASE_WAIT.
  - RELEASE_WAIT: `key_sync=1` returns to PRESSED. When `key_cnt` reaches DEBOUNCE_CYCLES-1, go to IDLE.
  - Holding the key yields exactly one pulse. Bounce on release yields none.
- **CPU read:**
  - `io_read_data` is a combinational mux of registered state: `display_data` when `io_sel=0`, `{15'b0,key_valid}` when `io_sel=1`.
  - `IORead && io_sel==0` clears `key_valid` on the next edge.
  - If a set and a clear fall in the same cycle, the set wins.
- **Width rule:** if SW_WIDTH < 16, `display_data` is zero-extended. If SW_WIDTH > 16, only bits [15:0] are captured.

## Timing
- Reset (`rst=0` at an edge) clears all flops. Every output reads 0, FSM in IDLE, both counters 0.
- A reset asserted mid-debounce or mid-press discards the partial count, and no pulse is emitted.
- A raw switch change is visible in `sw_sync` 2 edges later. `sw_stable` updates DEBOUNCE_CYCLES edges after that, provided there is no further change.
- Key press to `key_pulse`: 2 sync edges plus DEBOUNCE_CYCLES edges. `key_pulse` is high for exactly one cycle.
- `key_valid` rises on the same edge as `key_pulse` and falls one edge after a qualifying read.
- `io_read_data` is valid in the same cycle as `IORead`.

## Configuration
- `INPUT_DEBOUNCE_EN` defined: debounce behaves as described above.
- `INPUT_DEBOUNCE_EN` undefined: both counters are removed, for simulation speed.
  - `sw_stable` follows `sw_sync` with one extra register stage.
  - The FSM treats the confirm condition as met on the first cycle in PRESS_WAIT or RELEASE_WAIT, so press-to-pulse is 2 sync edges plus 1.
  - The synchronizers and all read, pulse and flag rules are unchanged.

## Structure
- Package `io_input_pkg` holds:
  - the key FSM state enum (2-bit);
  - IO_SEL_SW = 1'b0 and IO_SEL_KEY = 1'b1;
  - the default DEBOUNCE_CYCLES value.
- One sub-module, `input_sync`: a parameterized-width two-flop synchronizer with synchronous active-low reset, instanced once for `sw_in` and once for `key_in`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 with INPUT_DEBOUNCE_EN defined, unless stated otherwise.
- **Reset:** drive `rst=0` with `sw_in=16'hFFFF` and `key_in=1` -> all outputs 0; after `rst` returns to 1 -> `sw_stable=16'hFFFF` at the 6th edge (2 sync + 4 stable).
- **Switch bounce:** `sw_in` toggles 16'h00A5/16'h0000 every 2 cycles for 10 cycles, then holds 16'h00A5 -> `sw_stable` stays 0 until 6 edges after the last toggle, then reads 16'h00A5.
- **Clean press:** `sw_in=16'h1234`, key held 20 cycles -> exactly one `key_pulse`; `display_data=16'h1234`; `key_valid=1`; `io_sel=1` read returns 16'h0001.
- **Key bounce:** key pulses high for 2 cycles three times, then held -> one pulse only; release bouncing for 3 cycles then low -> no pulse.
- **Read clear and collision:** `IORead` with `io_sel=0` returns 16'h1234 and `key_valid` drops next edge; a read in the same cycle as a new confirm -> `key_valid` stays 1.
- **Mid-press reset and macro off:** `rst=0` in PRESS_WAIT -> no pulse, state IDLE; with INPUT_DEBOUNCE_EN undefined -> pulse 3 edges after `key_in` rises.

Source files
------------

// File: rtl/io_input_pkg.sv
// Shared types and constants for the switch/key input front end.
package io_input_pkg;

  typedef enum logic [1:0] {
    KEY_IDLE         = 2'd0,
    KEY_PRESS_WAIT   = 2'd1,
    KEY_PRESSED      = 2'd2,
    KEY_RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam logic IO_SEL_SW  = 1'b0;
  localparam logic IO_SEL_KEY = 1'b1;

  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;

endpackage

// File: rtl/input_sync.sv
// Two-flop synchronizer for asynchronous board pins, synchronous active-low reset.
module input_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/switch_key_input.sv
// Switch/confirm-key front end: sync, debounce, snapshot on press, CPU IO read mux.
// Define INPUT_DEBOUNCE_EN for real debouncing; otherwise the counters are dropped.
module switch_key_input
  import io_input_pkg::*;
#(
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SW_WIDTH-1:0] sw_in,
  input  logic                key_in,
  input  logic                IORead,
  input  logic                io_sel,
  output logic [15:0]         io_read_data,
  output logic [15:0]         display_data,
  output logic [SW_WIDTH-1:0] sw_stable,
  output logic                key_pulse,
  output logic                key_valid
);

  localparam int CAP_W = (SW_WIDTH < 16) ? SW_WIDTH : 16;

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_param_chk
    $error("switch_key_input: DEBOUNCE_CYCLES out of range 2..2^20");
  end

  logic [SW_WIDTH-1:0] sw_sync;
  logic                key_sync;

  input_sync #(.WIDTH(SW_WIDTH)) u_sw_sync (
    .clk (clk),
    .rst (rst),
    .d   (sw_in),
    .q   (sw_sync)
  );

  input_sync #(.WIDTH(1)) u_key_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_in),
    .q   (key_sync)
  );

  logic [SW_WIDTH-1:0] sw_stable_q, sw_stable_d;
  key_state_e          state_q, state_d;
  logic                key_pulse_q, key_pulse_d;
  logic                key_valid_q, key_valid_d;
  logic [15:0]         display_q, display_d;
  logic [15:0]         snap;
  logic                key_done;

`ifdef INPUT_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  // Load on the edge where the count reaches DEBOUNCE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [SW_WIDTH-1:0] sw_prev_q, sw_prev_d;
  logic [CNT_W-1:0]    sw_cnt_q, sw_cnt_d;
  logic [CNT_W-1:0]    key_cnt_q, key_cnt_d;
  logic                sw_change;

  always_comb begin
    sw_prev_d   = sw_sync;
    sw_change   = (sw_sync != sw_prev_q);
    sw_cnt_d    = sw_cnt_q;
    sw_stable_d = sw_stable_q;
    if (sw_change) begin
      sw_cnt_d = '0;
    end else begin
      if (sw_cnt_q < CNT_MAX) sw_cnt_d = sw_cnt_q + 1'b1;
      if (sw_cnt_q == CNT_HIT) sw_stable_d = sw_sync;
    end
  end

  assign key_done = (key_cnt_q == CNT_HIT);

  always_comb begin
    key_cnt_d = key_cnt_q;
    if (state_d != state_q) begin
      key_cnt_d = '0;
    end else if ((state_q == KEY_PRESS_WAIT || state_q == KEY_RELEASE_WAIT) &&
                 key_cnt_q < CNT_MAX) begin
      key_cnt_d = key_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_prev_q <= '0;
      sw_cnt_q  <= '0;
      key_cnt_q <= '0;
    end else begin
      sw_prev_q <= sw_prev_d;
      sw_cnt_q  <= sw_cnt_d;
      key_cnt_q <= key_cnt_d;
    end
  end
`else
  always_comb begin
    sw_stable_d = sw_sync;
  end

  assign key_done = 1'b1;
`endif

  always_comb begin
    snap            = '0;
    snap[CAP_W-1:0] = sw_stable_q[CAP_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    key_pulse_d = 1'b0;
    case (state_q)
`ifdef INPUT_DEBOUNCE_EN
      KEY_IDLE:    if (key_sync) state_d = KEY_PRESS_WAIT;
      KEY_PRESSED: if (!key_sync) state_d = KEY_RELEASE_WAIT;
`else
      // Without debounce the wait states have zero length: confirm immediately.
      KEY_IDLE: begin
        if (key_sync) begin
          state_d     = KEY_PRESSED;
          key_pulse_d = 1'b1;
        end
      end
      KEY_PRESSED: if (!key_sync) state_d = KEY_IDLE;
`endif
      KEY_PRESS_WAIT: begin
        if (!key_sync) begin
          state_d = KEY_IDLE;
        end else if (key_done) begin
          state_d     = KEY_PRESSED;
          key_pulse_d = 1'b1;
        end
      end
      KEY_RELEASE_WAIT: begin
        if (key_sync)      state_d = KEY_PRESSED;
        else if (key_done) state_d = KEY_IDLE;
      end
      default: state_d = KEY_IDLE;
    endcase
  end

  // A new snapshot beats a same-cycle read clear.
  always_comb begin
    key_valid_d = key_valid_q;
    display_d   = display_q;
    if (IORead && io_sel == IO_SEL_SW) key_valid_d = 1'b0;
    if (key_pulse_d) begin
      key_valid_d = 1'b1;
      display_d   = snap;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_stable_q <= '0;
      state_q     <= KEY_IDLE;
      key_pulse_q <= 1'b0;
      key_valid_q <= 1'b0;
      display_q   <= '0;
    end else begin
      sw_stable_q <= sw_stable_d;
      state_q     <= state_d;
      key_pulse_q <= key_pulse_d;
      key_valid_q <= key_valid_d;
      display_q   <= display_d;
    end
  end

  assign io_read_data = (io_sel == IO_SEL_KEY) ? {15'b0, key_valid_q} : display_q;
  assign display_data = display_q;
  assign sw_stable    = sw_stable_q;
  assign key_pulse    = key_pulse_q;
  assign key_valid    = key_valid_q;

endmodule

// File: tb/tb_switch_key_input.sv
// Directed bench for switch_key_input with DEBOUNCE_CYCLES=4, either macro setting.
module tb_switch_key_input;

`ifdef INPUT_DEBOUNCE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw_in;
  logic        key_in;
  logic        IORead;
  logic        io_sel;
  logic [15:0] io_read_data;
  logic [15:0] display_data;
  logic [15:0] sw_stable;
  logic        key_pulse;
  logic        key_valid;

  switch_key_input #(.SW_WIDTH(16), .DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .sw_in        (sw_in),
    .key_in       (key_in),
    .IORead       (IORead),
    .io_sel       (io_sel),
    .io_read_data (io_read_data),
    .display_data (display_data),
    .sw_stable    (sw_stable),
    .key_pulse    (key_pulse),
    .key_valid    (key_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sw;
    logic [15:0] exp;
  } sw_vec_t;

  typedef struct {
    logic        rd;
    logic        sel;
    logic [15:0] exp_rd;
    logic        exp_valid;
  } rd_vec_t;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int pulse_cnt = 0;
  int last_pulse = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Advance n clock edges, sampling 1 ns after each edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (key_pulse === 1'b1) begin
        pulse_cnt++;
        last_pulse = cyc;
      end
    end
  endtask

  sw_vec_t sw_tab[5];
  rd_vec_t rd_tab[6];

  initial begin
    int p0, c0;
    logic [15:0] prev;

    sw_tab[0] = '{16'h0001, 16'h0001};
    sw_tab[1] = '{16'h8000, 16'h8000};
    sw_tab[2] = '{16'h5A5A, 16'h5A5A};
    sw_tab[3] = '{16'hFFFF, 16'hFFFF};
    sw_tab[4] = '{16'h0000, 16'h0000};

    rd_tab[0] = '{1'b0, 1'b1, 16'h0001, 1'b1};
    rd_tab[1] = '{1'b0, 1'b0, 16'h1234, 1'b1};
    rd_tab[2] = '{1'b1, 1'b1, 16'h0001, 1'b1};
    rd_tab[3] = '{1'b1, 1'b0, 16'h1234, 1'b0};
    rd_tab[4] = '{1'b0, 1'b1, 16'h0000, 1'b0};
    rd_tab[5] = '{1'b1, 1'b0, 16'h1234, 1'b0};

    // Reset with inputs active
    rst = 1'b0; sw_in = 16'hFFFF; key_in = 1'b1; IORead = 1'b0; io_sel = 1'b0;
    step(3);
    chk("rst_sw_stable", sw_stable, 0);
    chk("rst_display", display_data, 0);
    chk("rst_key_pulse", key_pulse, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_rd_sw", io_read_data, 0);
    io_sel = 1'b1; #1;
    chk("rst_rd_key", io_read_data, 0);
    io_sel = 1'b0;
    key_in = 1'b0;
    rst = 1'b1;
    step(2 + LAT - 1);
    chk("rst_rel_early", sw_stable, 16'h0000);
    step(1);
    chk("rst_rel_stable", sw_stable, 16'hFFFF);

    // Switch vectors: old value just before the latency point, new value at it
    prev = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      sw_in = sw_tab[i].sw;
      step(2 + LAT - 1);
      chk($sformatf("swtab%0d_hold", i), sw_stable, prev);
      step(1);
      chk($sformatf("swtab%0d_new", i), sw_stable, sw_tab[i].exp);
      chk($sformatf("swtab%0d_disp", i), display_data, 16'h0000);
      prev = sw_tab[i].exp;
      step(2);
    end

    // Switch bounce: toggle every 2 cycles for 10 cycles, then hold
    for (int i = 0; i < 5; i++) begin
      sw_in = 16'h00A5;
      step(1);
`ifdef INPUT_DEBOUNCE_EN
      chk($sformatf("bnc_a%0d", i), sw_stable, 16'h0000);
`endif
      if (i == 4) break;
      step(1);
      sw_in = 16'h0000;
      step(2);
`ifdef INPUT_DEBOUNCE_EN
      chk($sformatf("bnc_z%0d", i), sw_stable, 16'h0000);
`endif
    end
    step(4);
`ifdef INPUT_DEBOUNCE_EN
    chk("bnc_before", sw_stable, 16'h0000);
`endif
    step(1);
    chk("bnc_after", sw_stable, 16'h00A5);

    // Clean press
    sw_in = 16'h1234;
    step(2 + LAT + 2);
    p0 = pulse_cnt; c0 = cyc;
    key_in = 1'b1;
    step(20);
    chk("press_pulses", pulse_cnt - p0, 1);
    chk("press_latency", last_pulse - c0, 2 + LAT);
    chk("press_display", display_data, 16'h1234);
    chk("press_valid", key_valid, 1);
    io_sel = 1'b1; #1;
    chk("press_rd_key", io_read_data, 16'h0001);
    key_in = 1'b0;
    step(20);
    chk("release_pulses", pulse_cnt - p0, 1);

    // CPU read table
    for (int i = 0; i < 6; i++) begin
      IORead = rd_tab[i].rd; io_sel = rd_tab[i].sel;
      #1;
      chk($sformatf("rdtab%0d_data", i), io_read_data, rd_tab[i].exp_rd);
      step(1);
      IORead = 1'b0;
      chk($sformatf("rdtab%0d_valid", i), key_valid, rd_tab[i].exp_valid);
    end

    // Key bounce on press, then hold
    p0 = pulse_cnt;
    for (int i = 0; i < 3; i++) begin
      key_in = 1'b1; step(2);
      key_in = 1'b0; step(2);
    end
    key_in = 1'b1;
    step(20);
`ifdef INPUT_DEBOUNCE_EN
    chk("kbnc_press_pulses", pulse_cnt - p0, 1);
`else
    chk("kbnc_press_pulses", pulse_cnt - p0, 4);
`endif
    // Release bounce
    p0 = pulse_cnt;
    key_in = 1'b0; step(1);
    key_in = 1'b1; step(1);
    key_in = 1'b0; step(1);
    key_in = 1'b1; step(1);
    key_in = 1'b0; step(20);
`ifdef INPUT_DEBOUNCE_EN
    chk("kbnc_release_pulses", pulse_cnt - p0, 0);
`else
    chk("kbnc_release_pulses", pulse_cnt - p0, 2);
`endif

    // Read clear colliding with a new confirm
    key_in = 1'b1;
    step(2 + LAT - 1);
    chk("coll_no_pulse_yet", key_pulse, 0);
    IORead = 1'b1; io_sel = 1'b0;
    step(1);
    IORead = 1'b0;
    chk("coll_pulse", key_pulse, 1);
    chk("coll_valid", key_valid, 1);
    step(1);
    chk("coll_valid_hold", key_valid, 1);
    IORead = 1'b1; io_sel = 1'b0;
    step(1);
    IORead = 1'b0;
    chk("clear_valid", key_valid, 0);
    key_in = 1'b0;
    step(2 + LAT + 4);

    // Reset in the middle of a press
    p0 = pulse_cnt;
    key_in = 1'b1;
`ifdef INPUT_DEBOUNCE_EN
    step(3);
`else
    step(2);
`endif
    rst = 1'b0;
    step(1);
    rst = 1'b1; key_in = 1'b0;
    step(5);
    chk("midrst_pulses", pulse_cnt - p0, 0);
    chk("midrst_valid", key_valid, 0);
    chk("midrst_display", display_data, 16'h0000);
    // Fresh press must show full latency from IDLE
    step(2 + LAT);
    c0 = cyc;
    key_in = 1'b1;
    step(2 + LAT - 1);
    chk("postrst_early", key_pulse, 0);
    step(1);
    chk("postrst_pulse", key_pulse, 1);
    chk("postrst_display", display_data, 16'h1234);
    step(1);
    chk("postrst_pulse_len", key_pulse, 0);
    chk("postrst_total", pulse_cnt - p0, 1);
    chk("postrst_latency", last_pulse - c0, 2 + LAT);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
